// File: rtl/motor_pwm_pkg.sv
// Shared register map, CTRL bit positions and bridge output modes for motor_pwm_array.
package motor_pwm_pkg;
    localparam logic [4:0] REG_PERIOD = 5'h00;
    localparam logic [4:0] REG_CTRL   = 5'h01;
    localparam logic [4:0] REG_WDOG   = 5'h02;
    localparam logic [4:0] REG_DUTY0  = 5'h03;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_BRAKE_BIT   = 1;
    localparam int CTRL_TIMEOUT_BIT = 8;
    localparam int DUTY_DIR_BIT     = 31;

    // Encoding is {b, a} so the mode bits drive the bridge pins directly.
    typedef enum logic [1:0] {
        COAST = 2'b00,
        FWD   = 2'b01,
        REV   = 2'b10,
        BRAKE = 2'b11
    } mode_e;

    function automatic mode_e sel_mode(input logic en, input logic brk, input logic tmo,
                                       input logic pwm, input logic dir);
        if (tmo) return brk ? BRAKE : COAST;
        if (!en || !pwm) return COAST;
        return dir ? REV : FWD;
    endfunction
endpackage

// File: rtl/motor_pwm_array_channel.sv
// One H-bridge channel: shadow/active duty, comparator against the shared counter, output mapping.
module pwm_channel
    import motor_pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_duty_i,
    input  logic             wr_dir_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             run_i,
    input  logic             enable_i,
    input  logic             brake_i,
    input  logic             timeout_i,
    output logic [CNT_W-1:0] shadow_duty_o,
    output logic             shadow_dir_o,
    output logic             a_o,
    output logic             b_o
);
    logic [CNT_W-1:0] sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
    logic             sh_dir_q, sh_dir_d, act_dir_q, act_dir_d;
    logic             a_q, b_q, pwm;
    mode_e            mode;
    logic [1:0]       mode_bits;

    always_comb begin
        sh_duty_d  = sh_duty_q;
        sh_dir_d   = sh_dir_q;
        act_duty_d = act_duty_q;
        act_dir_d  = act_dir_q;
        if (wr_i) begin
            sh_duty_d = wr_duty_i;
            sh_dir_d  = wr_dir_i;
        end
        // Active takes the pre-write shadow, so a write landing on a wrap waits one period.
        if (load_i) begin
            act_duty_d = sh_duty_q;
            act_dir_d  = sh_dir_q;
        end
        pwm  = run_i && (cnt_i < act_duty_q);
        mode = sel_mode(enable_i, brake_i, timeout_i, pwm, act_dir_q);
    end

    assign mode_bits = mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_duty_q  <= '0;
            sh_dir_q   <= 1'b0;
            act_duty_q <= '0;
            act_dir_q  <= 1'b0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
        end else begin
            sh_duty_q  <= sh_duty_d;
            sh_dir_q   <= sh_dir_d;
            act_duty_q <= act_duty_d;
            act_dir_q  <= act_dir_d;
            a_q        <= mode_bits[0];
            b_q        <= mode_bits[1];
        end
    end

    assign shadow_duty_o = sh_duty_q;
    assign shadow_dir_o  = sh_dir_q;
    assign a_o           = a_q;
    assign b_o           = b_q;
endmodule

// File: rtl/motor_pwm_array.sv
// Multi-channel H-bridge PWM with shared period counter, register bus and a safety watchdog.
module motor_pwm_array
    import motor_pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int WDOG_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic [NUM_CH-1:0] motor_a,
    output logic [NUM_CH-1:0] motor_b,
    output logic              timeout
);
    logic [CNT_W-1:0]  period_q, period_d, cnt_q, cnt_d;
    logic              en_q, en_d, brk_q, brk_d, timeout_q, timeout_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d, wd_q, wd_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [NUM_CH-1:0][CNT_W-1:0] sh_duty;
    logic [NUM_CH-1:0]            sh_dir, ch_wr;

    logic run, wrap, load, period_wr, ctrl_wr, wdog_wr, duty_wr, wd_active, expire;
    logic unused_wdata;

    assign unused_wdata = ^avs_writedata;

    assign period_wr = avs_write && (avs_address == REG_PERIOD);
    assign ctrl_wr   = avs_write && (avs_address == REG_CTRL);
    assign wdog_wr   = avs_write && (avs_address == REG_WDOG);
    assign duty_wr   = |ch_wr;

    assign run  = (period_q != '0);
    assign wrap = run && (cnt_q == period_q - CNT_W'(1));
    assign load = period_wr || wrap;

    assign wd_active = en_q && (wdog_q != '0);
    assign expire    = wd_active && (wd_q == WDOG_W'(1));

    always_comb begin
        period_d = period_wr ? avs_writedata[CNT_W-1:0] : period_q;
        en_d     = ctrl_wr ? avs_writedata[CTRL_EN_BIT] : en_q;
        brk_d    = ctrl_wr ? avs_writedata[CTRL_BRAKE_BIT] : brk_q;
        wdog_d   = wdog_wr ? avs_writedata[WDOG_W-1:0] : wdog_q;

        cnt_d = (period_wr || !run || wrap) ? '0 : cnt_q + CNT_W'(1);

        wd_d = wd_q;
        if (wdog_wr)
            wd_d = avs_writedata[WDOG_W-1:0];
        else if (ctrl_wr || duty_wr)
            wd_d = wdog_q;
        else if (wd_active && (wd_q != '0))
            wd_d = wd_q - WDOG_W'(1);

        // Expiry wins over a same-cycle CTRL clear so a late kick cannot mask a timeout.
        timeout_d = timeout_q;
        if (expire)
            timeout_d = 1'b1;
        else if (ctrl_wr)
            timeout_d = 1'b0;
    end

    always_comb begin
        rdata_d = '0;
        case (avs_address)
            REG_PERIOD: rdata_d[CNT_W-1:0] = period_q;
            REG_CTRL: begin
                rdata_d[CTRL_EN_BIT]      = en_q;
                rdata_d[CTRL_BRAKE_BIT]   = brk_q;
                rdata_d[CTRL_TIMEOUT_BIT] = timeout_q;
            end
            REG_WDOG: rdata_d[WDOG_W-1:0] = wdog_q;
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (avs_address == REG_DUTY0 + 5'(c)) begin
                        rdata_d[CNT_W-1:0]   = sh_duty[c];
                        rdata_d[DUTY_DIR_BIT] = sh_dir[c];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q  <= '0;
            en_q      <= 1'b0;
            brk_q     <= 1'b0;
            wdog_q    <= '0;
            cnt_q     <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            period_q  <= period_d;
            en_q      <= en_d;
            brk_q     <= brk_d;
            wdog_q    <= wdog_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            if (avs_read)
                rdata_q <= rdata_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_wr[c] = avs_write && (avs_address == REG_DUTY0 + 5'(c));

        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk           (clk),
            .reset         (reset),
            .wr_i          (ch_wr[c]),
            .wr_duty_i     (avs_writedata[CNT_W-1:0]),
            .wr_dir_i      (avs_writedata[DUTY_DIR_BIT]),
            .load_i        (load),
            .cnt_i         (cnt_q),
            .run_i         (run),
            .enable_i      (en_q),
            .brake_i       (brk_q),
            .timeout_i     (timeout_q),
            .shadow_duty_o (sh_duty[c]),
            .shadow_dir_o  (sh_dir[c]),
            .a_o           (motor_a[c]),
            .b_o           (motor_b[c])
        );
    end

    assign avs_readdata = rdata_q;
    assign timeout      = timeout_q;
endmodule
